// File: rtl/wb_arbiter.sv
// Writeback arbiter for the register file write port: ALU results take strict priority over a load-return FIFO.
// Optional build macro WB_LD_BYPASS_EN lets a load skip the empty FIFO and write in one cycle.
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  input  logic [ADDR_W-1:0]         alu_addr,
  input  logic [2:0]                alu_ppp,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [2:0]                ld_ppp,
  input  logic [DATA_W-1:0]         ld_data,
  input  logic                      ld_issue,
  input  logic [ADDR_W-1:0]         ld_issue_addr,
  output logic                      wr_en,
  output logic [2:0]                ppp,
  output logic [ADDR_W-1:0]         in_addr,
  output logic [DATA_W-1:0]         in_data,
  output logic [(2**ADDR_W)-1:0]    pend_mask,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [2:0]        ppp_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              bypass;

  logic              sel_valid;
  logic              sel_load;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_ppp;
  logic [DATA_W-1:0] sel_data;
  logic [2:0]        norm_ppp;
  logic [NREG-1:0]   pend_next;

  // Readiness depends on occupancy only, so a full FIFO refuses a push even while popping.
  assign ld_ready   = (fifo_count != CNT_W'(DEPTH));
  assign fifo_empty = (fifo_count == '0);

  always_comb begin
    sel_valid = 1'b0;
    sel_load  = 1'b0;
    sel_addr  = alu_addr;
    sel_ppp   = alu_ppp;
    sel_data  = alu_data;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
    end else if (!fifo_empty) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_addr  = addr_mem[rd_ptr];
      sel_ppp   = ppp_mem[rd_ptr];
      sel_data  = data_mem[rd_ptr];
    end
`ifdef WB_LD_BYPASS_EN
    else if (ld_valid) begin
      bypass    = 1'b1;
      sel_valid = 1'b1;
      sel_load  = 1'b1;
      sel_addr  = ld_addr;
      sel_ppp   = ld_ppp;
      sel_data  = ld_data;
    end
`endif
  end

  assign push     = ld_valid && ld_ready && !bypass;
  assign norm_ppp = (sel_ppp > 3'd4) ? 3'b000 : sel_ppp;

  // Storage needs no reset: entries are only read when the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= ld_addr;
      ppp_mem[wr_ptr]  <= ld_ppp;
      data_mem[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A load retiring and a new load issuing to the same register leave the bit set.
  always_comb begin
    pend_next = pend_mask;
    if (sel_load && (sel_addr != '0)) pend_next[sel_addr] = 1'b0;
    if (ld_issue && (ld_issue_addr != '0)) pend_next[ld_issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      ppp       <= '0;
      in_addr   <= '0;
      in_data   <= '0;
      pend_mask <= '0;
    end else begin
      wr_en     <= sel_valid && (sel_addr != '0);
      pend_mask <= pend_next;
      if (sel_valid) begin
        in_addr <= sel_addr;
        ppp     <= norm_ppp;
        in_data <= sel_data;
      end
    end
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback-side producer for the register file's single write port. It merges ALU results, which arrive every cycle and cannot stall, with load-return results, which are buffered in a small FIFO. It drives the registered write port: wr_en, ppp, in_addr and in_data. It also keeps a pending-load scoreboard that issue logic uses for load-use hazard detection.

Parameters:
DEPTH, 4, load-return FIFO entries (power of 2, >=2)
DATA_W, 64, result data width
ADDR_W, 5, register address width (32 registers)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result valid this cycle (no backpressure)
alu_addr  in  ADDR_W  ALU destination register
alu_ppp  in  3  ALU selective-write code
alu_data  in  DATA_W  ALU result
ld_valid  in  1  load-return result valid
ld_ready  out  1  FIFO can accept a load return
ld_addr  in  ADDR_W  load destination register
ld_ppp  in  3  load selective-write code
ld_data  in  DATA_W  load data
ld_issue  in  1  a load is issued this cycle (scoreboard set)
ld_issue_addr  in  ADDR_W  destination of the issued load
wr_en  out  1  register file write enable (registered)
ppp  out  3  register file write-select code (registered)
in_addr  out  ADDR_W  register file write address (registered)
in_data  out  DATA_W  register file write data (registered)
pend_mask  out  2**ADDR_W  bit i = load to register i outstanding (registered)
fifo_count  out  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst=1):
  - wr_en, ppp, in_addr, in_data, pend_mask and fifo_count all 0.
  - FIFO pointers are cleared; any in-flight entries are discarded.
  - ld_ready=1 while rst is high and after release.
- Load handshake:
  - ld_ready = (fifo_count != DEPTH), combinational from count only.
  - A push occurs on a rising edge with ld_valid && ld_ready.
  - ld_valid with ld_ready=0 is not accepted; the source holds its data.
- Arbitration, every edge:
  - If alu_valid, the ALU result is selected. ALU has strict priority.
  - Else if the FIFO is non-empty, the head entry is popped and selected.
  - Else nothing is selected: wr_en<=0, and ppp/in_addr/in_data hold their previous values.
- Output register:
  - On selection, in_addr, in_data and ppp load from the winner.
  - wr_en <= (selected addr != 0).
  - ppp codes 3'b101–3'b111 are normalised to 3'b000 on output.
  - A selected entry with addr 0 still pops the FIFO but produces wr_en=0.
- Latency:
  - ALU: accepted at edge N, wr_en visible after edge N (1 cycle).
  - Load: pushed at edge N, earliest write after edge N+1.
- Simultaneous push and pop: both occur; fifo_count is unchanged. When full, ld_ready stays 0 that cycle, even though a pop is happening.
- Ordering: loads write back in FIFO order. ALU and load writes are not reordered against each other beyond the priority rule.
- Scoreboard:
  - ld_issue with ld_issue_addr!=0 sets pend_mask[ld_issue_addr] at the edge.
  - A load result written with wr_en=1 clears pend_mask[in_addr] at the same edge the output register loads.
  - If the same register is set and cleared at one edge, set wins.
  - Address 0 is never set.
  - ALU writes do not affect pend_mask.
- FIFO wrap-around: pointers wrap modulo DEPTH. fifo_count never exceeds DEPTH and never underflows.

Optional Feature:
WB_LD_BYPASS_EN
- Defined: when alu_valid=0, the FIFO is empty and ld_valid=1, the load goes directly to the output register at that edge and is not pushed. Load latency becomes 1 cycle.
- Not defined: every load passes through the FIFO, so minimum load latency is 2 cycles.
- ld_ready semantics are identical in both builds.

Test Plan:
- Reset: assert rst mid-stream with 3 entries queued -> asynchronously wr_en=0, fifo_count=0, pend_mask=0, ld_ready=1; the queued entries never write.
- ALU only: alu_valid, addr=5, ppp=3'b001, data=0x1122334455667788 at edge N -> after N: wr_en=1, in_addr=5, ppp=3'b001, in_data=0x1122334455667788; next idle cycle -> wr_en=0.
- Contention:
  - Setup: push loads to r7, r8, r9, r10 while alu_valid is high for 6 cycles.
  - Required: only ALU writes appear; fifo_count=4 and ld_ready=0.
  - After alu_valid drops: r7, r8, r9, r10 write in order on 4 consecutive cycles.
- Scoreboard:
  - ld_issue r12 -> pend_mask[12]=1.
  - Load return r12 -> bit clears on the write edge.
  - ld_issue r12 at that same edge -> bit stays 1.
- Address 0 / ppp normalisation:
  - Load to r0 -> popped, wr_en=0, fifo_count decrements.
  - ALU with ppp=3'b110 to r3 -> output ppp=3'b000.
- Bypass, built with and without WB_LD_BYPASS_EN: idle pipe, single load r4 data 0xDEADBEEF00000001 -> wr_en after 1 edge if defined, after 2 edges if not.
